// File: rtl/dx_reg_rdy.sv
// dx_reg_rdy: two-entry valid/ready register slice (main + skid). m_valid, m_data and s_ready all come from flops.
// Latency: a word accepted while empty, or while busy with a simultaneous drain, is on m_data the next cycle. A skidded word waits for its predecessor to drain.
// Backpressure: s_ready drops the cycle after both entries fill and rises the cycle after the drain that leaves full; m_ready has no combinational path to s_ready.
module dx_reg_rdy #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    // Occupancy: EMPTY = no words, BUSY = main only, FULL = main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  r_m_valid;
    logic                  r_s_ready;

    logic                  w_accept;
    logic                  w_drain;

    // Handshakes are qualified only by our own flopped valid/ready.
    assign w_accept = s_valid & r_s_ready;
    assign w_drain  = r_m_valid & m_ready;

    // Occupancy FSM. Main, skid, m_valid and s_ready are all updated here so every output stays a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b0;
            r_main    <= '0;
            r_skid    <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    // s_ready is still low on the first cycle out of reset; raise it here.
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        r_main    <= s_data;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && w_drain) begin
                        // Pass-through: the new word replaces the one leaving.
                        r_main <= s_data;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new word and close the input.
                        r_skid    <= s_data;
                        r_s_ready <= 1'b0;
                        r_state   <= ST_FULL;
                    end else if (w_drain) begin
                        r_m_valid <= 1'b0;
                        r_state   <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // No accept can occur here because s_ready is low.
                    if (w_drain) begin
                        r_main    <= r_skid;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                default: begin
                    r_state   <= ST_EMPTY;
                    r_m_valid <= 1'b0;
                    r_s_ready <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_main;

endmodule

// File: tb/tb_dx_reg_rdy.sv
// Bench for dx_reg_rdy: table vectors with fixed expected outputs, plus a queue scoreboard that runs on every cycle.
// Latency: the bench samples outputs 1 ns after each rising edge and drives inputs at that point too.
// Backpressure: m_ready is driven by the table, by the hand-written sequences, and randomly during stress.
module tb_dx_reg_rdy;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    dx_reg_rdy #(.DATA_WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_ready(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard: words are pushed on a modelled accept and popped on a modelled drain.
    logic [7:0] sb_q[$];
    logic       exp_ready = 1'b0;
    int         obs_acc   = 0;
    int         obs_drn   = 0;
    int         seen_bad  = 0;
    logic       guard_bad = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the pre-edge inputs, then check the DUT against the model.
    task automatic tick();
        logic       stall;
        logic [7:0] held;
        stall = m_valid && !m_ready;
        held  = m_data;
        if (s_valid && s_ready) obs_acc++;
        if (m_valid && m_ready) obs_drn++;
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
            exp_ready = 1'b0;
        end else begin
            logic acc;
            logic drn;
            acc = s_valid && exp_ready;
            drn = m_ready && (sb_q.size() > 0);
            if (drn) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(s_data);
            exp_ready = (sb_q.size() < 2);
        end
        #1;
        chk("sb_m_valid", {31'd0, m_valid}, {31'd0, sb_q.size() > 0});
        if (sb_q.size() > 0) chk("sb_m_data", {24'd0, m_data}, {24'd0, sb_q[0]});
        chk("sb_s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
        if (stall && !rst) chk("stall_hold", {24'd0, m_data}, {24'd0, held});
        if (guard_bad && m_valid && (m_data == 8'h31 || m_data == 8'h32)) seen_bad++;
    endtask

    typedef struct {
        logic       rst;
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       mv;
        logic [7:0] md;
        logic       md_chk;
        logic       sr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic sv, input logic [7:0] sd, input logic mr,
                                input logic mv, input logic [7:0] md, input logic mdc, input logic sr);
        vec_t v;
        v.rst = r; v.sv = sv; v.sd = sd; v.mr = mr;
        v.mv = mv; v.md = md; v.md_chk = mdc; v.sr = sr;
        vecs.push_back(v);
    endfunction

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;

        // Reset held for three edges while 0xAA is offered.
        for (int i = 0; i < 3; i++) add(1, 1, 8'hAA, 0, 0, 8'h00, 1, 0);
        // First edge out of reset: s_ready rises, 0xAA is not taken.
        add(0, 1, 8'hAA, 1, 0, 8'h00, 1, 1);
        add(0, 0, 8'h00, 1, 0, 8'h00, 1, 1);
        // Streaming 0x01..0x10 at full rate.
        for (int k = 1; k <= 16; k++) add(0, 1, 8'(k), 1, 1, 8'(k), 1, 1);
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
        // Backpressure fill: 0x21 to main, 0x22 to skid, 0x23 held upstream.
        add(0, 1, 8'h21, 0, 1, 8'h21, 1, 1);
        add(0, 1, 8'h22, 0, 1, 8'h21, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 8'h23, 0, 1, 8'h21, 1, 0);
        // Drain from full: 0x22 moves up, then 0x23 is accepted once s_ready returns.
        add(0, 1, 8'h23, 1, 1, 8'h22, 1, 1);
        add(0, 1, 8'h23, 1, 1, 8'h23, 1, 1);
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            m_ready = vecs[i].mr;
            tick();
            chk($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].mv});
            chk($sformatf("vec%0d_s_ready", i), {31'd0, s_ready}, {31'd0, vecs[i].sr});
            if (vecs[i].md_chk) chk($sformatf("vec%0d_m_data", i), {24'd0, m_data}, {24'd0, vecs[i].md});
        end

        // Mid-operation reset while full with 0x31/0x32.
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h31; tick();
        s_data = 8'h32; tick();
        chk("midrst_full_sready", {31'd0, s_ready}, 32'd0);
        guard_bad = 1'b1;
        rst = 1'b1; s_valid = 1'b0; tick();
        chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        rst = 1'b0; m_ready = 1'b1; tick();
        chk("midrst_sready_back", {31'd0, s_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1; s_data = 8'h40 + 8'(k); tick();
            chk($sformatf("post_rst_%0d", k), {24'd0, m_data}, {24'd0, 8'h40 + 8'(k)});
        end
        s_valid = 1'b0; tick(); tick();
        chk("no_31_32_output", seen_bad, 0);
        guard_bad = 1'b0;

        // Random stress with the scoreboard checking every cycle.
        obs_acc = 0;
        obs_drn = 0;
        for (int c = 0; c < 2000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            tick();
        end
        s_valid = 1'b0;
        chk("occupancy", obs_acc - obs_drn, sb_q.size());
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("drained_empty", {31'd0, m_valid}, 32'd0);
        chk("drained_sb", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dx_reg_rdy.md
Name: dx_reg_rdy

Overview:
- Two-entry valid/ready register slice (skid buffer) for DATA_WIDTH streams.
- Companion to the plain forward pipeline register: the forward register breaks only the data path; this block also registers the backward (ready) path.
- m_valid, m_data and s_ready all come straight from flops, so the slice can go between any two handshake stages for timing closure.
- Full throughput, no bubbles, no loss, no reordering.

Parameters:
- DATA_WIDTH, 8, width of s_data/m_data in bits (>=1).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- s_data  input  DATA_WIDTH  upstream data.
- s_valid  input  1  upstream data valid.
- s_ready  output  1  slice can accept; registered.
- m_data  output  DATA_WIDTH  downstream data; registered.
- m_valid  output  1  downstream data valid; registered.
- m_ready  input  1  downstream accepts.

Behaviour:
- Transfer definitions: an accept is s_valid & s_ready at a posedge; a drain is m_valid & m_ready at a posedge.
- Storage: main register (drives m_data) plus skid register; state encodes occupancy.
- States:
  - EMPTY (0 words): m_valid=0, s_ready=1.
  - BUSY (1 word in main): m_valid=1, s_ready=1.
  - FULL (main + skid): m_valid=1, s_ready=0.
- Transitions:
  - EMPTY: accept -> BUSY, main<=s_data.
  - BUSY: accept & drain -> BUSY, main<=s_data. Accept & !drain -> FULL, skid<=s_data. Drain & !accept -> EMPTY. Neither -> hold.
  - FULL: drain -> BUSY, main<=skid. No accept is possible, since s_ready=0.
- Latency: a word accepted at edge N appears on m_data with m_valid=1 after edge N (visible in cycle N+1) when the slice was EMPTY, or when it was BUSY with a simultaneous drain.
- Throughput: 1 word/cycle sustained while m_ready=1.
- Stability: while m_valid=1 & m_ready=0, m_data and m_valid hold unchanged.
- Ordering: output order equals accept order. Each accepted word is drained exactly once.
- s_ready is a function of registered state only, with no combinational path from m_ready. It deasserts the cycle after FULL is entered and reasserts the cycle after the FULL-exiting drain.
- s_data is ignored when s_valid=0 or s_ready=0. The upstream may change s_valid/s_data freely while s_ready=0.
- Reset (rst=1 at a posedge), regardless of state:
  - state<=EMPTY, m_valid<=0, s_ready<=0, main<=0, skid<=0.
  - s_ready rises to 1 at the first posedge with rst=0.
  - In-flight words are discarded; reset mid-FULL loses both words.
- m_valid never depends combinationally on s_valid.

Test Plan:
- Reset: hold rst=1 for 3 cycles with s_valid=1, s_data=8'hAA -> m_valid=0, m_data=8'h00, s_ready=0. After release, s_ready=1 one edge later, and no 8'hAA appears on the output.
- Streaming: m_ready=1, send 8'h01..8'h10 on consecutive cycles -> m_data shows 8'h01..8'h10 consecutively, each one cycle after its accept; s_ready stays 1 and there are no gaps.
- Backpressure fill: m_ready=0, offer 8'h21, 8'h22, 8'h23 back-to-back.
  - 8'h21 goes to main (BUSY) and 8'h22 goes to skid (FULL).
  - s_ready=0, and 8'h23 is held upstream.
  - m_data=8'h21 stays stable for all m_ready=0 cycles.
- Drain from FULL: from the previous state, set m_ready=1 -> output sequence is 8'h21, 8'h22, 8'h23 with 8'h23 accepted once s_ready returns. No loss and no duplicates.
- Random stress: 2000 cycles of $random s_valid/m_ready/s_data with a scoreboard queue, checking:
  - output matches accept order;
  - m_data is stable under stall;
  - s_ready never 1 while FULL;
  - final occupancy equals accepts minus drains.
- Mid-operation reset: reach FULL with 8'h31/8'h32, assert rst for 1 cycle -> m_valid=0 next cycle. Neither 8'h31 nor 8'h32 is ever output, and subsequent traffic 8'h40.. flows correctly.
